finv_full_pipe: RTL and testbench
=================================

# finv_full_pipe

Full single-precision reciprocal pipeline wrapping the mantissa-only reciprocal core `finv_pipe`. Accepts an IEEE-754 binary32 operand, sends its mantissa to `finv_pipe`, and carries the sign, exponent and special-case class alongside in a matched delay line. It then merges these with the core result into a final binary32 reciprocal with status flags. It feeds the FPU result mux and the `fdiv` datapath, where x/y is computed as x·finv(y).

## Interface
Parameters:
- `MANT_LAT`, default 4: latency of the instantiated `finv_pipe`, in cycles, from `m` to `res`. It must match the core exactly.

Ports:
- `clk`  in  1  — single clock.
- `rstn`  in  1  — reset. Asynchronous assert, active-low.
- `in_valid`  in  1  — operand valid this cycle.
- `x`  in  32  — binary32 operand.
- `out_valid`  out  1  — result valid this cycle. Reset value 0.
- `res`  out  32  — binary32 reciprocal. Reset value 32'h0.
- `dz`  out  1  — divide-by-zero flag (operand is zero or denormal). Reset value 0.
- `nv`  out  1  — invalid flag (operand is NaN). Reset value 0.

## Operation
- Fully pipelined, free-running, no stall. One operand is accepted per cycle.
- Input decode:
  - s = x[31], e = x[30:23], m = x[22:0].
  - `m` drives `finv_pipe` directly every cycle, whether or not `in_valid` is set.
- Class, decoded at input:
  - ZERO: e==0. Denormals are treated as zero.
  - INF: e==255 and m==0.
  - NAN: e==255 and m!=0.
  - NORM: otherwise.
- Delay line: {in_valid, s, e, class} passes through a MANT_LAT-deep shift register clocked every cycle. Its tap aligns with the core `res` output.
- Merge, at the aligned stage. Let c = core result with exponent ce = c[30:23].
  - Compute out_e = ce + 127 − e in 10-bit signed arithmetic. Zero-extend ce and e first.
  - NORM, out_e ≤ 0: res = {s, 31'h0}. This flushes to signed zero; no denormals are produced.
  - NORM, out_e ≥ 255: res = {s, 8'hFF, 23'h0}. This cannot occur for legal inputs but is required.
  - NORM, otherwise: res = {s, out_e[7:0], c[22:0]}.
  - ZERO: res = {s, 8'hFF, 23'h0}, dz=1.
  - INF: res = {s, 31'h0}.
  - NAN: res = 32'h7FC00000, nv=1.
- Output register: `res`, `dz`, `nv` and `out_valid` are registered once after the merge.
  - When the delayed valid is 0, out_valid=0. In that case `res` and the flags may take any value, but must not be X in simulation.
- Core sign bit c[31] is ignored. Mantissa accuracy is whatever `finv_pipe` provides; this block adds no rounding.

## Timing
- Latency is MANT_LAT+1 cycles. An operand accepted at edge k appears with out_valid=1 after edge k+MANT_LAT+1.
- Throughput is 1 result per cycle. Back-to-back operands stay in order with no bubbles.
- Reset, whenever it occurs:
  - All delay-line valid bits, out_valid, res, dz and nv clear asynchronously.
  - In-flight operands are discarded.
  - After rstn deasserts, the first valid output appears MANT_LAT+1 cycles after the first accepted operand.
  - No spurious out_valid pulse is allowed during or after reset.
- Sideband state (s, e, class) may be left unreset. Only valid bits and outputs require reset.
- `finv_pipe` uses synchronous reset internally. The bench must hold rstn low for at least MANT_LAT+1 clock edges so the core also flushes.

## Test plan
- x=32'h40000000 (2.0), single valid pulse -> after MANT_LAT+1 cycles: out_valid=1 for exactly one cycle, res=32'h3F000000, dz=0, nv=0.
- x=32'h3F800000 and x=32'hC0800000 (−4.0) on consecutive cycles -> res=32'h3F800000, then res=32'hBE800000 on consecutive cycles, in order. Additionally, 1000 random NORM operands back to back, checked against a reference model within the core's error bound, exponent and sign exact.
- x=32'h00000000, then x=32'h80000001 (negative denormal) -> res=32'h7F800000 with dz=1, then res=32'hFF800000 with dz=1.
- x=32'hFF800000 -> res=32'h80000000, flags 0. x=32'h7F800001 -> res=32'h7FC00000, nv=1.
- x=32'h7F000000 (2^127) -> res=32'h00000000 (flush to zero). x=32'h00800000 (2^−126) -> res=32'h7E800000.
- Stream of valid operands, then rstn pulsed low mid-stream for MANT_LAT+1 cycles -> out_valid=0 immediately on assert. No stale results emerge after release. The first post-reset operand appears exactly MANT_LAT+1 cycles later.

Source files
------------

// File: rtl/finv_full_pipe.sv
// rtl/finv_full_pipe.sv - binary32 reciprocal pipeline around the finv_pipe mantissa core

module finv_pipe #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [22:0] m,
    output logic [31:0] res
);
    logic [48:0] w_num;
    logic [48:0] w_den;
    logic [48:0] w_q;
    logic        w_one;
    logic [31:0] w_c;
    logic [31:0] r_q [LAT];

    // 2^47 / 1.m as a 24-bit fixed-point quotient; 1.0 only when m == 0
    assign w_num = 49'h1 << 47;
    assign w_den = {25'd0, 1'b1, m};
    assign w_q   = w_num / w_den;
    assign w_one = (w_q[48:23] != 26'd1);
    assign w_c   = w_one ? {1'b0, 8'd127, 23'd0} : {1'b0, 8'd126, w_q[22:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) r_q[i] <= '0;
        end else begin
            r_q[0] <= w_c;
            for (int i = 1; i < LAT; i++) r_q[i] <= r_q[i-1];
        end
    end

    assign res = r_q[LAT-1];
endmodule

module finv_full_pipe #(
    parameter int MANT_LAT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] x,
    output logic        out_valid,
    output logic [31:0] res,
    output logic        dz,
    output logic        nv
);
    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

    cls_t              w_cls;
    logic [31:0]       w_core;
    logic              w_unused_sign;
    logic              r_vld [MANT_LAT];
    logic              r_s   [MANT_LAT];
    logic [7:0]        r_e   [MANT_LAT];
    cls_t              r_cls [MANT_LAT];
    logic signed [9:0] w_oe;
    logic [31:0]       w_res;
    logic              w_dz;
    logic              w_nv;

    always_comb begin
        w_cls = CLS_NORM;
        if (x[30:23] == 8'd0)           w_cls = CLS_ZERO;
        else if (x[30:23] == 8'hFF)     w_cls = (x[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end

    finv_pipe #(.LAT(MANT_LAT)) u_core (
        .clk  (clk),
        .rstn (rstn),
        .m    (x[22:0]),
        .res  (w_core)
    );

    assign w_unused_sign = w_core[31];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MANT_LAT; i++) r_vld[i] <= 1'b0;
        end else begin
            r_vld[0] <= in_valid;
            for (int i = 1; i < MANT_LAT; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    // Sideband is qualified by r_vld everywhere, so it needs no reset
    always_ff @(posedge clk) begin
        r_s[0]   <= x[31];
        r_e[0]   <= x[30:23];
        r_cls[0] <= w_cls;
        for (int i = 1; i < MANT_LAT; i++) begin
            r_s[i]   <= r_s[i-1];
            r_e[i]   <= r_e[i-1];
            r_cls[i] <= r_cls[i-1];
        end
    end

    assign w_oe = $signed({2'b00, w_core[30:23]}) + 10'sd127 - $signed({2'b00, r_e[MANT_LAT-1]});

    always_comb begin
        w_res = 32'h0;
        w_dz  = 1'b0;
        w_nv  = 1'b0;
        if (r_vld[MANT_LAT-1]) begin
            case (r_cls[MANT_LAT-1])
                CLS_NORM: begin
                    if (w_oe <= 10'sd0)        w_res = {r_s[MANT_LAT-1], 31'h0};
                    else if (w_oe >= 10'sd255) w_res = {r_s[MANT_LAT-1], 8'hFF, 23'h0};
                    else                       w_res = {r_s[MANT_LAT-1], w_oe[7:0], w_core[22:0]};
                end
                CLS_ZERO: begin
                    w_res = {r_s[MANT_LAT-1], 8'hFF, 23'h0};
                    w_dz  = 1'b1;
                end
                CLS_INF: w_res = {r_s[MANT_LAT-1], 31'h0};
                default: begin
                    w_res = 32'h7FC00000;
                    w_nv  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            res       <= 32'h0;
            dz        <= 1'b0;
            nv        <= 1'b0;
        end else begin
            out_valid <= r_vld[MANT_LAT-1];
            res       <= w_res;
            dz        <= w_dz;
            nv        <= w_nv;
        end
    end
endmodule

// File: tb/tb_finv_full_pipe.sv
// tb/tb_finv_full_pipe.sv - scoreboard bench for finv_full_pipe

module tb_finv_full_pipe;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] x = 32'h0;
    logic        out_valid;
    logic [31:0] res;
    logic        dz;
    logic        nv;

    typedef struct {
        logic [31:0] xi;
        logic        exact;
        logic [31:0] er;
        logic        edz;
        logic        env;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    finv_full_pipe #(.MANT_LAT(LAT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid),
        .res       (res),
        .dz        (dz),
        .nv        (nv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] xi, input logic exact, input logic [31:0] er,
                         input logic edz, input logic env);
        exp_t item;
        @(negedge clk);
        in_valid = 1'b1;
        x        = xi;
        item.xi = xi; item.exact = exact; item.er = er; item.edz = edz; item.env = env;
        item.due = cyc + LAT + 1;
        sb.push_back(item);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_norm();
        logic [7:0] e;
        e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    exp_t  got_item;
    int    oe;
    real   mreal;
    real   diff;

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                got_item = sb.pop_front();
                check("latency", cyc, got_item.due);
                if (got_item.exact) begin
                    check("res", res, got_item.er);
                    check("dz", {31'd0, dz}, {31'd0, got_item.edz});
                    check("nv", {31'd0, nv}, {31'd0, got_item.env});
                end else begin
                    oe = (got_item.xi[22:0] == 23'd0) ? 254 - int'(got_item.xi[30:23])
                                                      : 253 - int'(got_item.xi[30:23]);
                    if (oe <= 0) begin
                        check("rnd_flush", res, {got_item.xi[31], 31'h0});
                    end else begin
                        check("rnd_signexp", {23'd0, res[31:23]}, {23'd0, got_item.xi[31], oe[7:0]});
                        mreal = (got_item.xi[22:0] == 23'd0) ? 0.0 :
                                (2.0 / (1.0 + real'(got_item.xi[22:0]) / 8388608.0) - 1.0) * 8388608.0;
                        diff = real'(res[22:0]) - mreal;
                        check("rnd_mant_tol", {31'd0, (diff <= 1.0 && diff >= -1.0)}, 32'd1);
                    end
                    check("rnd_flags", {30'd0, dz, nv}, 32'd0);
                end
            end
        end
    end

    initial begin
        #2 rstn = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_res", res, 32'h0);
        check("rst_flags", {30'd0, dz, nv}, 32'd0);
        rstn = 1'b1;
        idle(2);

        drive(32'h40000000, 1'b1, 32'h3F000000, 1'b0, 1'b0);
        idle(LAT + 3);
        drive(32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0);
        drive(32'hC0800000, 1'b1, 32'hBE800000, 1'b0, 1'b0);
        drive(32'h00000000, 1'b1, 32'h7F800000, 1'b1, 1'b0);
        drive(32'h80000001, 1'b1, 32'hFF800000, 1'b1, 1'b0);
        drive(32'hFF800000, 1'b1, 32'h80000000, 1'b0, 1'b0);
        drive(32'h7F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        drive(32'h7F800001, 1'b1, 32'h7FC00000, 1'b0, 1'b1);
        drive(32'hFFC00000, 1'b1, 32'h7FC00000, 1'b0, 1'b1);
        drive(32'h7F000000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        drive(32'h00800000, 1'b1, 32'h7E800000, 1'b0, 1'b0);
        drive(32'h3FC00000, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(LAT + 3);

        for (int i = 0; i < 1000; i++) drive(rand_norm(), 1'b0, 32'h0, 1'b0, 1'b0);
        idle(LAT + 3);

        for (int i = 0; i < 8; i++) drive(rand_norm(), 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rstn     = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        check("rst_async_valid", {31'd0, out_valid}, 32'd0);
        check("rst_async_res", res, 32'h0);
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        idle(LAT + 3);
        drive(32'h40000000, 1'b1, 32'h3F000000, 1'b0, 1'b0);
        idle(1);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        check("drain", sb.size(), 32'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
